mux_nto1_arb: RTL
=================

# mux_nto1_arb

Parametrised N-to-1 registered multiplexer with per-channel valid/ready handshakes and a round-robin arbiter. It replaces the combinational 2:1 select mux on shared datapaths where several producers feed one consumer. It also keeps a manual mode in which an external select forces a single channel, as the old 2:1 select did. The output is a single registered stage with full one-beat-per-cycle throughput.

## Interface
- N, default 8: number of input channels, 2..256.
- D, default 8: data width per channel.
- S, default 3: select/pointer width, must satisfy 2^S >= N.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*D  channel k occupies bits [k*D+D-1 : k*D].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational.
- force_en  input  1  manual mode enable.
- force_sel  input  S  channel index used when force_en=1.
- out_data  output  D  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer accept.
- out_sel  output  S  index of the channel that supplied out_data.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Load enable: load_en = !out_valid || out_ready.
- Eligible set:
  - force_en=0: all k with in_valid[k]=1.
  - force_en=1: only k=force_sel, and only if in_valid[force_sel]=1.
- Grant, with MUX_NTO1_RR_EN defined: the first eligible channel found scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[g] = load_en && (g is granted). All other in_ready bits are 0, so at most one bit is high.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - out_data <= slice g.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1.
- load_en=1 with an empty eligible set: out_valid <= 0. out_data, out_sel and ptr hold.
- load_en=0: out_data, out_sel, out_valid and ptr all hold.
- Manual-mode transfers also advance ptr.
- Sources must hold in_valid and data stable until accepted. The block does not drop accepted beats.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is all 0 while rst=1.
- Latency: a beat accepted at edge t is presented on out_data/out_valid after edge t.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready is all 0 and the output register holds.
- Same cycle out_ready=1 and a new grant: the old beat leaves and the new beat loads on the same edge (no bubble).
- Non-power-of-two N: ptr wraps from N-1 to 0. ptr never holds a value >= N.
- force_sel >= N with force_en=1: nothing is eligible, in_ready is all 0, and the output drains.
- force_en/force_sel changes take effect in the same cycle's grant. A beat already in the output register is unaffected.
- rst asserted mid-stream: the held beat is discarded and all state returns to reset values immediately, regardless of clk.

## Configuration
- MUX_NTO1_RR_EN defined: round-robin arbitration from ptr, as described above.
- MUX_NTO1_RR_EN undefined: fixed priority, lowest index eligible wins. ptr is not implemented, and the grant is independent of history.
- Handshake, manual mode and timing are identical in both builds.

## Structure
- Shared package mux_pkg holds:
  - Default constants MUX_N_DEF=8, MUX_D_DEF=8, MUX_S_DEF=3.
  - A clog2 function used for S checks.
  - An elaboration check that 2^S >= N.
- Sub-module rr_arb (N, S): inputs req[N-1:0], ptr; outputs one-hot gnt[N-1:0] and binary gnt_idx[S-1:0]. Holds no state; ptr lives in mux_nto1_arb.

## Test plan
- Reset release, N=8 D=8, idle inputs, out_ready=1 -> out_valid=0, out_data=0x00, out_sel=0, in_ready=0x00 for 5 cycles.
- in_valid=0xFF held, in_data slice k = 0x10+k, out_ready=1 (RR build):
  - out_sel sequence 0,1,2,…,7,0 on consecutive cycles; out_data 0x10…0x17.
  - Fixed-priority build: out_sel stays 0.
- Channels 2 and 5 valid, out_ready low 3 cycles then high:
  - in_ready=0 while stalled, and out_data holds the first beat (0x12).
  - Then channel 5 is delivered (0x15), with no duplicates or drops.
- force_en=1, force_sel=6, in_valid=0xFF -> only in_ready[6] ever asserts; out_sel=6 every cycle. With force_sel=6 and in_valid[6]=0 -> out_valid falls after one cycle.
- N=5, all valid, RR -> out_sel wraps 3,4,0,1; force_sel=7 -> in_ready all 0.
- rst pulsed asynchronously between edges with out_valid=1 -> out_valid drops within the pulse, without waiting for clk. The next grant starts from channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the N-to-1 arbitrated mux.
// Round-robin arbitration is selected at build time with MUX_NTO1_RR_EN.
package mux_pkg;

    localparam int MUX_N_DEF = 8;
    localparam int MUX_D_DEF = 8;
    localparam int MUX_S_DEF = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // True when an S-bit index can address every one of n channels.
    function automatic bit sel_width_ok(input int n, input int s);
        return clog2(n) <= s;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Stateless rotating-priority arbiter: first requester at or after ptr wins.
// With ptr tied to zero it degenerates to lowest-index-first priority.
module rr_arb #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic [N-1:0] req,
    input  logic [S-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [S-1:0] gnt_idx
);

    int  w_idx;
    logic w_found;

    // ptr is always < N, so a single subtraction is enough to wrap the scan.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = S'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_arb.sv
// N-to-1 registered mux with valid/ready per channel, manual force mode and
// an arbiter; define MUX_NTO1_RR_EN for round-robin, otherwise fixed priority.
module mux_nto1_arb
    import mux_pkg::*;
#(
    parameter int N = MUX_N_DEF,
    parameter int D = MUX_D_DEF,
    parameter int S = MUX_S_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*D-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           force_en,
    input  logic [S-1:0]   force_sel,
    output logic [D-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [S-1:0]   out_sel
);

    if (N < 2 || N > 256 || !sel_width_ok(N, S)) begin : g_cfg_check
        $error("mux_nto1_arb: need 2 <= N <= 256 and 2^S >= N");
    end

    logic           r_out_valid;
    logic [D-1:0]   r_out_data;
    logic [S-1:0]   r_out_sel;
    logic           w_load_en;
    logic           w_xfer;
    logic [N-1:0]   w_req;
    logic [N-1:0]   w_gnt;
    logic [S-1:0]   w_gnt_idx;
    logic [S-1:0]   w_ptr;

    assign w_load_en = !r_out_valid || out_ready;

    // In manual mode an out-of-range force_sel leaves nothing eligible.
    always_comb begin
        w_req = '0;
        if (!force_en) begin
            w_req = in_valid;
        end else if (int'(force_sel) < N) begin
            w_req[force_sel] = in_valid[force_sel];
        end
    end

`ifdef MUX_NTO1_RR_EN
    logic [S-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_idx == S'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    rr_arb #(
        .N(N),
        .S(S)
    ) u_arb (
        .req    (w_req),
        .ptr    (w_ptr),
        .gnt    (w_gnt),
        .gnt_idx(w_gnt_idx)
    );

    assign in_ready = (w_load_en && !rst) ? w_gnt : '0;
    assign w_xfer   = |(in_ready & in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[int'(w_gnt_idx)*D +: D];
                r_out_sel   <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
